// File: rtl/pkg_cachorro.sv
// Shared types and constants for the pet-device movement path.
package pkg_cachorro;

  localparam int unsigned DEF_T_SHORT = 2;
  localparam int unsigned DEF_T_MED   = 4;
  localparam int unsigned DEF_T_LONG  = 8;
  localparam int unsigned DEF_CNT_W   = 4;
  localparam int unsigned DUR_W       = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [DUR_W-1:0] DUR_NONE = 2'b00;
  localparam logic [DUR_W-1:0] DUR_2S   = 2'b01;
  localparam logic [DUR_W-1:0] DUR_4S   = 2'b10;
  localparam logic [DUR_W-1:0] DUR_8S   = 2'b11;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector; a held level produces a single pulse.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/movement_sequencer.sv
// Runs one timed motor cycle from the duration switches and the 1 Hz tick,
// and flags invalid switch selections.
module movement_sequencer
  import pkg_cachorro::*;
#(
  parameter int unsigned T_SHORT = DEF_T_SHORT,
  parameter int unsigned T_MED   = DEF_T_MED,
  parameter int unsigned T_LONG  = DEF_T_LONG,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1s,
  input  logic             sel_2s,
  input  logic             sel_4s,
  input  logic             sel_8s,
  input  logic             ld,
  input  logic             start,
  input  logic             abort,
  output logic             motor_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] remaining,
  output logic [1:0]       dur_code
);

  state_t           state, state_n;
  logic             start_rise_c;
  logic             sel_ok_c;
  logic             count_c;
  logic [CNT_W-1:0] load_cnt_c;
  logic [1:0]       load_dur_c;

  rise_detect u_start_rise (
    .clk    (clk),
    .rst_n  (rst_n),
    .d      (start),
    .rise_c (start_rise_c)
  );

  // Exactly one switch selects a duration; anything else is invalid.
  always_comb begin
    sel_ok_c   = 1'b1;
    load_cnt_c = '0;
    load_dur_c = DUR_NONE;
    case ({sel_8s, sel_4s, sel_2s})
      3'b001: begin load_cnt_c = CNT_W'(T_SHORT); load_dur_c = DUR_2S; end
      3'b010: begin load_cnt_c = CNT_W'(T_MED);   load_dur_c = DUR_4S; end
      3'b100: begin load_cnt_c = CNT_W'(T_LONG);  load_dur_c = DUR_8S; end
      default: sel_ok_c = 1'b0;
    endcase
  end

  assign count_c = tick_1s & ld & (remaining != '0);

  // State register plus the seconds counter and latched duration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      dur_code  <= DUR_NONE;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (state_n == RUN) begin
            remaining <= load_cnt_c;
            dur_code  <= load_dur_c;
          end
        end
        RUN: begin
          if (abort) begin
            remaining <= '0;
            dur_code  <= DUR_NONE;
          end else if (count_c) begin
            remaining <= remaining - CNT_W'(1);
          end
        end
        default: remaining <= '0;
      endcase
    end
  end

  // Next-state logic; abort outranks both start and a final tick.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (!abort && start_rise_c) state_n = sel_ok_c ? RUN : ERROR;
      end
      RUN: begin
        if (abort)                                        state_n = IDLE;
        else if (count_c && (remaining == CNT_W'(1)))     state_n = DONE;
      end
      DONE:    state_n = IDLE;
      ERROR: begin
        if (sel_ok_c || abort) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs decoded from the state register; motor follows ld with no delay.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    motor_en = 1'b0;
    case (state)
      RUN: begin
        busy     = 1'b1;
        motor_en = ld;
      end
      DONE:    done = 1'b1;
      ERROR:   err  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_movement_sequencer.sv
// Self-checking bench for movement_sequencer: vector table, directed corner cases,
// and random stimulus against a flag-based reference model.
module tb_movement_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, tick_1s, sel_2s, sel_4s, sel_8s, ld, start, abort;
  logic       motor_en, busy, done, err;
  logic [3:0] remaining;
  logic [1:0] dur_code;

  int errors = 0;
  int checks = 0;

  // Reference model: plain flags and an integer seconds counter.
  bit         m_run, m_err, m_done, m_prev_start;
  int         m_left;
  logic [1:0] m_dur;

  typedef struct {
    logic       st;
    logic       ab;
    logic [2:0] sel;
    logic       l;
    logic       tk;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  movement_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1s   (tick_1s),
    .sel_2s    (sel_2s),
    .sel_4s    (sel_4s),
    .sel_8s    (sel_8s),
    .ld        (ld),
    .start     (start),
    .abort     (abort),
    .motor_en  (motor_en),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .remaining (remaining),
    .dur_code  (dur_code)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] dut_outs();
    return {busy, err, done, motor_en, remaining, dur_code};
  endfunction

  function automatic logic [10:0] model_outs();
    return {m_run, m_err, m_done, m_run & ld, 4'(m_left), m_dur};
  endfunction

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: busy/err/done/motor/rem/dur got %b required %b", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_err = 0; m_done = 0; m_prev_start = 0; m_left = 0; m_dur = 2'b00;
  endtask

  task automatic model_step();
    bit rise, ok;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rise = start && !m_prev_start;
    ok   = (int'(sel_2s) + int'(sel_4s) + int'(sel_8s)) == 1;
    m_prev_start = start;
    if (m_run) begin
      if (abort) begin
        m_run = 0; m_left = 0; m_dur = 2'b00;
      end else if (tick_1s && ld) begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_run = 0; m_done = 1; end
      end
    end else if (m_err) begin
      if (ok || abort) m_err = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!abort && rise) begin
      if (ok) begin
        m_run  = 1;
        m_left = sel_2s ? 2 : (sel_4s ? 4 : 8);
        m_dur  = sel_2s ? 2'b01 : (sel_4s ? 2'b10 : 2'b11);
      end else begin
        m_err = 1;
      end
    end
  endtask

  // One clock: advance the model, then compare DUT against it away from the edge.
  task automatic cyc(input string name);
    @(posedge clk);
    model_step();
    #1;
    check({name, "/model"}, dut_outs(), model_outs());
  endtask

  task automatic drive(input logic st, input logic ab, input logic [2:0] sel,
                       input logic l, input logic tk);
    start = st; abort = ab; {sel_8s, sel_4s, sel_2s} = sel; ld = l; tick_1s = tk;
  endtask

  task automatic add_vec(input logic st, input logic ab, input logic [2:0] sel,
                         input logic l, input logic tk, input logic [10:0] exp);
    vec_t v;
    v.st = st; v.ab = ab; v.sel = sel; v.l = l; v.tk = tk; v.exp = exp;
    vecs.push_back(v);
  endtask

  int done_cnt, run_cnt;
  logic busy_prev;

  initial begin
    // sel field is {sel_8s, sel_4s, sel_2s}; exp is {busy,err,done,motor,rem[3:0],dur}
    add_vec(1, 0, 3'b010, 1, 0, 11'b1001_0100_10);  // 4s start
    add_vec(0, 0, 3'b010, 1, 1, 11'b1001_0011_10);
    add_vec(0, 0, 3'b010, 1, 0, 11'b1001_0011_10);
    add_vec(0, 0, 3'b010, 1, 1, 11'b1001_0010_10);
    add_vec(0, 0, 3'b010, 1, 1, 11'b1001_0001_10);
    add_vec(0, 0, 3'b010, 1, 1, 11'b0010_0000_10);  // done pulse
    add_vec(0, 0, 3'b010, 1, 0, 11'b0000_0000_10);
    add_vec(1, 1, 3'b001, 1, 0, 11'b0000_0000_10);  // start+abort in IDLE
    add_vec(0, 0, 3'b001, 1, 0, 11'b0000_0000_10);
    add_vec(1, 0, 3'b101, 1, 0, 11'b0100_0000_10);  // two switches
    add_vec(0, 0, 3'b101, 1, 0, 11'b0100_0000_10);
    add_vec(0, 0, 3'b001, 1, 0, 11'b0000_0000_10);  // cleared -> IDLE
    add_vec(1, 0, 3'b000, 1, 0, 11'b0100_0000_10);  // no switch
    add_vec(0, 1, 3'b000, 1, 0, 11'b0000_0000_10);
    add_vec(1, 0, 3'b001, 1, 1, 11'b1001_0010_01);  // entry tick ignored
    add_vec(0, 0, 3'b001, 1, 1, 11'b1001_0001_01);
    add_vec(0, 1, 3'b001, 1, 1, 11'b0000_0000_00);  // abort beats final tick
    add_vec(0, 0, 3'b001, 1, 0, 11'b0000_0000_00);

    rst_n = 1'b0;
    drive(0, 0, 3'b000, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset_state", dut_outs(), 11'b0);
    @(negedge clk) rst_n = 1'b1;
    cyc("idle0");
    cyc("idle1");

    foreach (vecs[i]) begin
      drive(vecs[i].st, vecs[i].ab, vecs[i].sel, vecs[i].l, vecs[i].tk);
      cyc($sformatf("vec%0d", i));
      check($sformatf("vec%0d", i), dut_outs(), vecs[i].exp);
    end

    // Async reset mid-run with 3 seconds left.
    drive(1, 0, 3'b010, 1, 0); cyc("rst_run_start");
    drive(0, 0, 3'b010, 1, 1); cyc("rst_run_tick");
    check("rst_run_rem3", dut_outs(), 11'b1001_0011_10);
    drive(0, 0, 3'b010, 1, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("rst_async_zero", dut_outs(), 11'b0);
    cyc("rst_hold");
    @(negedge clk) rst_n = 1'b1;
    drive(0, 0, 3'b010, 1, 1);
    for (int i = 0; i < 4; i++) begin
      cyc("rst_after");
      check("rst_after_idle", dut_outs(), 11'b0);
    end

    // Pause: 8s run, ld low for 5 ticks after 3 counted ticks.
    drive(1, 0, 3'b100, 1, 0); cyc("pause_start");
    check("pause_load", dut_outs(), 11'b1001_1000_11);
    for (int i = 0; i < 3; i++) begin drive(0, 0, 3'b100, 1, 1); cyc("pause_run"); end
    check("pause_rem5", dut_outs(), 11'b1001_0101_11);
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 3'b100, 0, 1); cyc("pause_hold");
      check("pause_frozen", dut_outs(), 11'b1000_0101_11);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 3'b100, 1, 1); cyc("pause_resume");
      check("pause_count", dut_outs(), {4'b1001, 4'(4 - i), 2'b11});
    end
    drive(0, 0, 3'b100, 1, 1); cyc("pause_last");
    check("pause_done", dut_outs(), 11'b0010_0000_11);
    drive(0, 0, 3'b100, 1, 0); cyc("pause_idle");

    // Held start: one run only until released and pressed again.
    done_cnt = 0; run_cnt = 0; busy_prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 3'b001, 1, 1); cyc("held");
      if (done) done_cnt++;
      if (busy && !busy_prev) run_cnt++;
      busy_prev = busy;
    end
    check("held_done_cnt", 11'(done_cnt), 11'd1);
    check("held_run_cnt", 11'(run_cnt), 11'd1);
    drive(0, 0, 3'b001, 1, 0); cyc("held_release");
    check("held_release_idle", dut_outs(), 11'b0000_0000_01);
    drive(1, 0, 3'b001, 1, 0); cyc("held_repress");
    check("held_repress_run", dut_outs(), 11'b1001_0010_01);

    // Random stimulus against the model.
    for (int n = 0; n < 4000; n++) begin
      logic [2:0] sel;
      if ($urandom_range(0, 7) < 6) sel = 3'(1 << $urandom_range(0, 2));
      else                          sel = 3'($urandom_range(0, 7));
      drive(($urandom_range(0, 4) == 0) ? ~start : start,
            $urandom_range(0, 19) == 0,
            ($urandom_range(0, 15) == 0) ? sel : {sel_8s, sel_4s, sel_2s},
            $urandom_range(0, 7) != 0,
            $urandom_range(0, 2) == 0);
      cyc("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
